// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer:
// MDU opcode encodings, default latencies, counter width and FSM state type.
package e_mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Wide enough for any sensible latency setting.
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for ops that occupy the multi-cycle datapath.
  function automatic logic mdu_is_long(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_timer.sv
// Loadable down-counter for the MDU latency window.
// done is high during the final busy cycle (count == 1).
module e_mdu_timer import e_mdu_ctrl_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load on issue, otherwise decrement until it reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: computes mult/div results into 64-bit
// shadow registers at issue, models the fixed latency with e_mdu_timer and
// commits HI/LO when the window expires. Owns the HI/LO architectural state.
// Optional build macro MDU_DIV0_FAST_EN: divide-by-zero completes in zero
// cycles (no busy window) instead of occupying the full divide latency.
module e_mdu_ctrl import e_mdu_ctrl_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUres
);

  mdu_state_e       state_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [63:0]      shadow_r;     // {sHI, sLO}
  logic             commit_r;     // cleared for divide-by-zero
  logic             busy_r;

  logic             issue_s;
  logic             long_s;
  logic             wr_s;
  logic [63:0]      res_s;
  logic [CNT_W-1:0] lat_s;
  logic             done_s;
  logic             div0_s;
  logic [31:0]      b_safe_s;
  logic [63:0]      sprod_s;
  logic [63:0]      uprod_s;
  logic [31:0]      squot_s;
  logic [31:0]      srem_s;
  logic [31:0]      uquot_s;
  logic [31:0]      urem_s;

  assign issue_s  = start & ~req & (state_r == ST_IDLE);
  assign div0_s   = (B == 32'd0);
  // Substitute divisor keeps the divider defined; result is discarded on B==0.
  assign b_safe_s = div0_s ? 32'd1 : B;
  assign sprod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign uprod_s  = {32'd0, A} * {32'd0, B};
  assign squot_s  = $signed(A) / $signed(b_safe_s);
  assign srem_s   = $signed(A) % $signed(b_safe_s);
  assign uquot_s  = A / b_safe_s;
  assign urem_s   = A % b_safe_s;

  // Decode the issuing op into result, latency and whether it enters RUN.
  always_comb begin
    res_s  = 64'd0;
    lat_s  = {CNT_W{1'b0}};
    long_s = 1'b0;
    wr_s   = 1'b0;
    case (MDUop)
      MDU_MULT:  begin res_s = sprod_s; lat_s = CNT_W'(MULT_LAT); long_s = 1'b1; wr_s = 1'b1; end
      MDU_MULTU: begin res_s = uprod_s; lat_s = CNT_W'(MULT_LAT); long_s = 1'b1; wr_s = 1'b1; end
      MDU_DIV:   begin res_s = {srem_s, squot_s}; lat_s = CNT_W'(DIV_LAT); long_s = 1'b1; wr_s = ~div0_s; end
      MDU_DIVU:  begin res_s = {urem_s, uquot_s}; lat_s = CNT_W'(DIV_LAT); long_s = 1'b1; wr_s = ~div0_s; end
      default:   begin res_s = 64'd0; lat_s = {CNT_W{1'b0}}; long_s = 1'b0; wr_s = 1'b0; end
    endcase
`ifdef MDU_DIV0_FAST_EN
    if ((MDUop == MDU_DIV || MDUop == MDU_DIVU) && div0_s) begin
      long_s = 1'b0;
    end else begin
      long_s = long_s;
    end
`endif
  end

  e_mdu_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (issue_s & long_s),
    .load_val (lat_s),
    .done     (done_s)
  );

  // Sequencer FSM plus HI/LO and shadow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      shadow_r <= 64'd0;
      commit_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s && long_s) begin
            shadow_r <= res_s;
            commit_r <= wr_s;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else if (issue_s && MDUop == MDU_MTHI) begin
            hi_r <= A;
          end else if (issue_s && MDUop == MDU_MTLO) begin
            lo_r <= A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (done_s) begin
            if (commit_r) begin
              hi_r <= shadow_r[63:32];
              lo_r <= shadow_r[31:0];
            end else begin
              hi_r <= hi_r;
            end
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Same-cycle HI/LO read for mfhi/mflo.
  always_comb begin
    case (MDUop)
      MDU_MFHI: MDUres = hi_r;
      MDU_MFLO: MDUres = lo_r;
      default:  MDUres = 32'd0;
    endcase
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- E-stage multi-cycle multiply/divide sequencer that sits beside the E-stage ALU in the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo issued with the E-stage instruction.
- Models fixed mult/div latency with a countdown, owns the HI/LO architectural registers, and exports busy so the D-stage hazard unit can stall MDU-class instructions.
- Honours exception/interrupt flush (req) so a faulting or interrupted instruction never commits HI/LO.

Parameters:
- MULT_LAT, 5: busy cycles for mult/multu.
- DIV_LAT, 10: busy cycles for div/divu.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt flush for the current cycle; suppresses any issue this cycle.
- start  in  1  E-stage instruction is a valid MDU op this cycle.
- MDUop  in  4  operation code from const.v: MDU_none, mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- A  in  32  rs value (forwarded).
- B  in  32  rt value (forwarded).
- busy  out  1  mult/div in progress.
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDUres  out  32  combinational read: HI when MDUop=mfhi, LO when MDUop=mflo, else 0.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE, cnt=0, HI=LO=0, busy=0, shadow registers=0.
  - Reset mid-operation aborts the operation; HI/LO stay 0.
- States: IDLE and RUN.
- Issue condition: issue = start & ~req & (state==IDLE).
- IDLE, issue with mult/multu/div/divu:
  - Capture the result into shadow registers sHI/sLO at the issuing edge.
  - mult: signed 64-bit product of A×B. multu: unsigned 64-bit product.
  - div: sLO = signed quotient truncated toward zero; sHI = remainder with the sign of the dividend. divu: unsigned quotient and remainder.
  - Load cnt = LAT (MULT_LAT or DIV_LAT); go to RUN.
- IDLE, issue with mthi/mtlo: HI←A or LO←A at that edge; no busy cycle.
- mfhi/mflo: no state change; MDUres reflects HI/LO pre-edge (same cycle).
- RUN:
  - busy=1 every cycle; cnt decrements each edge.
  - On the edge where cnt==1: HI←sHI, LO←sLO, state→IDLE.
  - Result: busy is high for exactly LAT cycles starting the cycle after issue; new HI/LO are visible in cycle issue+LAT+1.
- Divide by zero (B==0): runs the full DIV_LAT; HI/LO are left unchanged at completion.
- start while state==RUN: ignored. The hazard unit guarantees this never happens; the bench flags it as a protocol error.
- req:
  - Blocks issue in its own cycle, including mthi/mtlo.
  - Does not abort an operation already in RUN; an issued op was architecturally committed and completes.
- Simultaneous completion edge and new start: start is ignored (state==RUN that cycle); the hazard unit holds the instruction one more cycle.
- Arithmetic: shadows are 64-bit; sign extension of A/B applies for mult/div only.

Optional Feature:
- Macro MDU_DIV0_FAST_EN.
- Defined: div/divu with B==0 sets no busy, stays IDLE, and leaves HI/LO unchanged (zero-cycle completion).
- Undefined: divide-by-zero occupies the full DIV_LAT busy window as specified above.
- All other ops are identical in both builds.

Decomposition:
- const.v (shared include) holds the MDU_* opcode defines next to the ALU_* defines, plus the default latencies MULT_LAT_DEF and DIV_LAT_DEF.
- One natural sub-module, e_mdu_timer: loadable down-counter with a done pulse. The controller instantiates it once.
- Arithmetic and HI/LO stay in e_mdu_ctrl.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002: busy high cycles 1–5 after issue; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE; busy for exactly 5 cycles.
- div A=0xFFFFFFF9 (−7), B=2: busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=0xFFFFFFF9, B=2: LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678 with req=1: HI unchanged. Repeat with req=0: HI=0x12345678 next cycle, and mfhi returns it via MDUres.
- Issue div, assert req at cycle 3: op still completes. Then issue mult and assert reset at cycle 2: busy=0, HI=LO=0 the next cycle.
- div with B=0:
  - Without MDU_DIV0_FAST_EN: busy for 10 cycles, HI/LO unchanged.
  - With MDU_DIV0_FAST_EN: busy never asserted, HI/LO unchanged.
